// File: rtl/finish_irq.sv
// -----------------------------------------------------------------------------
// finish_irq
//
// Purpose
//   Job-completion interrupt block. A single-cycle start pulse arms the block
//   for one job. While it is armed, a rising edge on finish marks the job done.
//   The block then sets a sticky status flag, bumps a saturating completion
//   counter and raises a registered, maskable interrupt. An optional watchdog
//   ends a job that runs too long and flags it as a timeout instead.
//
// Configuration
//   FINISH_IRQ_TIMEOUT_EN  When defined, the watchdog counter and the timeout
//                          status bit (status[1]) are built. When undefined,
//                          there is no watchdog at all: status[1] reads 0,
//                          timeout_cycles and irq_clr[1] are ignored, and
//                          ARMED ends only on a finish event.
//
// Ports
//   clk             in   1   rising-edge clock for all state
//   rstn            in   1   synchronous reset, ACTIVE-HIGH (1 = reset)
//   start           in   1   single-cycle arm pulse (used only in IDLE)
//   finish          in   1   job-complete level; its rising edge is the event
//   irq_mask        in   1   1 = hold irq low (status still records events)
//   irq_clr         in   2   write-1-to-clear per status bit: [0] done, [1] timeout
//   timeout_cycles  in   32  watchdog limit in cycles while armed; 0 = disabled
//   irq             out  1   registered interrupt request
//   status          out  2   sticky flags: [0] done, [1] timeout
//   busy            out  1   high while the FSM is ARMED
//   done_cnt        out  16  completed-job count, saturates at 0xFFFF
// -----------------------------------------------------------------------------
module finish_irq (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        finish,
  input  logic        irq_mask,
  input  logic [1:0]  irq_clr,
  input  logic [31:0] timeout_cycles,
  output logic        irq,
  output logic [1:0]  status,
  output logic        busy,
  output logic [15:0] done_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01,
    EVENT = 2'b10
  } state_e;

  state_e      state_q,    state_d;
  logic        finish_d_q;
  logic [1:0]  status_q,   status_d;
  logic [15:0] done_cnt_q, done_cnt_d;
  logic        irq_q,      irq_d;
  logic        set_done;
  logic        fin_evt;

  // A finish event is a rising edge of finish. The delayed copy is captured
  // in every state, so a level that is already high when the block arms
  // does not count as an event.
  assign fin_evt = finish & ~finish_d_q;

`ifdef FINISH_IRQ_TIMEOUT_EN
  logic [31:0] wd_q, wd_d;
  logic        set_tmo;
  logic        wd_expire;

  // The watchdog expires on the cycle in which the count would reach the
  // limit. An ARMED entry at edge E0 therefore times out at edge
  // E0 + timeout_cycles.
  assign wd_expire = (timeout_cycles != '0) && ((wd_q + 32'd1) == timeout_cycles);
`else
  // With the watchdog compiled out, these inputs have no effect.
  logic unused_inputs;
  assign unused_inputs = ^{timeout_cycles, irq_clr[1]};
`endif

  // ---------------------------------------------------------------------------
  // Next-state, status and counter logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    done_cnt_d = done_cnt_q;
    set_done   = 1'b0;
`ifdef FINISH_IRQ_TIMEOUT_EN
    wd_d       = wd_q;
    set_tmo    = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ARMED;
`ifdef FINISH_IRQ_TIMEOUT_EN
          wd_d    = '0;
`endif
        end
      end

      ARMED: begin
`ifdef FINISH_IRQ_TIMEOUT_EN
        if (timeout_cycles != '0) begin
          wd_d = wd_q + 32'd1;
        end
`endif
        // If a finish event and watchdog expiry land in the same cycle,
        // the finish event takes precedence.
        if (fin_evt) begin
          set_done = 1'b1;
          state_d  = EVENT;
          if (done_cnt_q != '1) begin
            done_cnt_d = done_cnt_q + 16'd1;
          end
        end
`ifdef FINISH_IRQ_TIMEOUT_EN
        else if (wd_expire) begin
          set_tmo = 1'b1;
          state_d = EVENT;
        end
`endif
      end

      EVENT: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Sticky flags: a set in the same cycle overrides a write-1-to-clear.
    status_d[0] = set_done | (status_q[0] & ~irq_clr[0]);
`ifdef FINISH_IRQ_TIMEOUT_EN
    status_d[1] = set_tmo  | (status_q[1] & ~irq_clr[1]);
`else
    status_d[1] = 1'b0;
`endif

    // irq follows the registered status, so it trails a status change by
    // one cycle.
    irq_d = (status_q[0] | status_q[1]) & ~irq_mask;
  end

  // ---------------------------------------------------------------------------
  // State registers (synchronous, active-high reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q    <= IDLE;
      finish_d_q <= 1'b0;
      status_q   <= '0;
      done_cnt_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      finish_d_q <= finish;
      status_q   <= status_d;
      done_cnt_q <= done_cnt_d;
      irq_q      <= irq_d;
    end
  end

`ifdef FINISH_IRQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rstn) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign irq      = irq_q;
  assign status   = status_q;
  assign busy     = (state_q == ARMED);
  assign done_cnt = done_cnt_q;

endmodule

// File: tb/tb_finish_irq.sv
// -----------------------------------------------------------------------------
// tb_finish_irq
//
// Self-checking bench for finish_irq. The first part is a vector table: each
// row holds the inputs applied for one clock edge and the outputs expected
// just after that edge. Hand-written sequences then cover the multi-cycle
// corners: finish held high across arming, counter saturation, reset in the
// middle of a job, and the watchdog (or its absence, depending on
// FINISH_IRQ_TIMEOUT_EN).
// -----------------------------------------------------------------------------
module tb_finish_irq;

  logic        clk;
  logic        rstn;
  logic        start;
  logic        finish;
  logic        irq_mask;
  logic [1:0]  irq_clr;
  logic [31:0] timeout_cycles;
  logic        irq;
  logic [1:0]  status;
  logic        busy;
  logic [15:0] done_cnt;

  int unsigned n_pass;
  int unsigned n_total;

  finish_irq dut (
    .clk            (clk),
    .rstn           (rstn),
    .start          (start),
    .finish         (finish),
    .irq_mask       (irq_mask),
    .irq_clr        (irq_clr),
    .timeout_cycles (timeout_cycles),
    .irq            (irq),
    .status         (status),
    .busy           (busy),
    .done_cnt       (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL sim_timeout: simulation time limit exceeded (actual=running, required=finished)");
    $fatal(1, "simulation time limit exceeded");
  end

  typedef struct {
    logic        rst;
    logic        start;
    logic        finish;
    logic        mask;
    logic [1:0]  clr;
    logic        e_irq;
    logic [1:0]  e_status;
    logic        e_busy;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic st, input logic fin,
                              input logic mask, input logic [1:0] clr,
                              input logic e_irq, input logic [1:0] e_status,
                              input logic e_busy, input logic [15:0] e_cnt);
    vec_t v;
    v.rst = rst; v.start = st; v.finish = fin; v.mask = mask; v.clr = clr;
    v.e_irq = e_irq; v.e_status = e_status; v.e_busy = e_busy; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic drive(input logic rst, input logic st, input logic fin,
                       input logic mask, input logic [1:0] clr);
    rstn     = rst;
    start    = st;
    finish   = fin;
    irq_mask = mask;
    irq_clr  = clr;
  endtask

  // Inputs change on the falling edge; outputs are sampled on the next
  // falling edge, half a cycle after the rising edge that updated them.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_all(input string tag, input logic e_irq, input logic [1:0] e_status,
                         input logic e_busy, input logic [15:0] e_cnt);
    chk({tag, " irq"},      {31'd0, irq},      {31'd0, e_irq});
    chk({tag, " status"},   {30'd0, status},   {30'd0, e_status});
    chk({tag, " busy"},     {31'd0, busy},     {31'd0, e_busy});
    chk({tag, " done_cnt"}, {16'd0, done_cnt}, {16'd0, e_cnt});
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    timeout_cycles = 32'd0;

    //    rst  start fin  mask clr     irq  status busy cnt
    // Reset, then a job whose finish rises 5 cycles after arming.
    add(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 16'd0);  // 0 reset
    add(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 16'd0);  // 1 arm
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 16'd0);  // 2
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 16'd0);  // 3
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 16'd0);  // 4
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 16'd0);  // 5
    add(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b01, 1'b0, 16'd1);  // 6 finish edge
    add(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 2'b01, 1'b0, 16'd1);  // 7 irq follows
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b01, 1'b0, 16'd1);  // 8
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 16'd1);  // 9 clear done
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 16'd1);  // 10 irq drops
    add(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 16'd1);  // 11 finish edge in IDLE
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 16'd1);  // 12
    // Masked completion, then unmask and clear.
    add(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b1, 16'd1);  // 13 arm
    add(1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 2'b01, 1'b0, 16'd2);  // 14 finish
    add(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 2'b01, 1'b0, 16'd2);  // 15 masked
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b01, 1'b0, 16'd2);  // 16 unmask
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 16'd2);  // 17 clear
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 16'd2);  // 18
    // Set beats a simultaneous clear.
    add(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 16'd2);  // 19 arm
    add(1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 2'b01, 1'b0, 16'd3);  // 20 set+clr
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b01, 1'b0, 16'd3);  // 21
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 16'd3);  // 22
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 16'd3);  // 23
    // start is ignored in ARMED and EVENT.
    add(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 16'd3);  // 24 arm
    add(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 16'd3);  // 25 start in ARMED
    add(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b01, 1'b0, 16'd4);  // 26 finish
    add(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 2'b01, 1'b0, 16'd4);  // 27 start in EVENT
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 16'd4);  // 28 still IDLE
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 16'd4);  // 29

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].start, vecs[i].finish, vecs[i].mask, vecs[i].clr);
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].e_irq, vecs[i].e_status,
              vecs[i].e_busy, vecs[i].e_cnt);
    end

    // finish already high before start and held: no event until it drops
    // and rises again.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00); tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 2'b00); tick();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 2'b00); tick();
    chk_all("held_arm", 1'b0, 2'b00, 1'b1, 16'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("held_hi%0d", i), 1'b0, 2'b00, 1'b1, 16'd0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00); tick();
    chk_all("held_low", 1'b0, 2'b00, 1'b1, 16'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 2'b00); tick();
    chk_all("held_rise", 1'b0, 2'b01, 1'b0, 16'd1);

    // Saturation: preload the counter to 0xFFFF, then complete another job.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    force dut.done_cnt_d = 16'hFFFF;
    tick();
    release dut.done_cnt_d;
    chk_all("sat_pre", 1'b0, 2'b00, 1'b0, 16'hFFFF);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b00); tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 2'b00); tick();
    chk_all("sat_job", 1'b0, 2'b01, 1'b0, 16'hFFFF);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00); tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b00); tick();
    chk_all("mid_armed", 1'b1, 2'b01, 1'b1, 16'hFFFF);

    // Reset while ARMED, with finish rising in the same cycle: reset wins.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 2'b00); tick();
    chk_all("mid_rst", 1'b0, 2'b00, 1'b0, 16'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 2'b00); tick();
    chk_all("post_rst", 1'b0, 2'b00, 1'b0, 16'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00); tick();

`ifdef FINISH_IRQ_TIMEOUT_EN
    // Watchdog of 10: timeout ten cycles after arming, no finish.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00); tick();
    timeout_cycles = 32'd10;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b00); tick();
    chk_all("tmo10_arm", 1'b0, 2'b00, 1'b1, 16'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    for (int i = 1; i < 10; i++) tick();
    chk_all("tmo10_c9", 1'b0, 2'b00, 1'b1, 16'd0);
    tick();
    chk_all("tmo10_c10", 1'b0, 2'b10, 1'b0, 16'd0);
    tick();
    chk_all("tmo10_irq", 1'b1, 2'b10, 1'b0, 16'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b10); tick();
    chk_all("tmo10_clr", 1'b1, 2'b00, 1'b0, 16'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00); tick();
    chk_all("tmo10_idle", 1'b0, 2'b00, 1'b0, 16'd0);

    // Watchdog of 4 with finish rising on the expiry cycle: done wins.
    timeout_cycles = 32'd4;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b00); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    for (int i = 1; i < 4; i++) tick();
    chk_all("tmo4_c3", 1'b0, 2'b00, 1'b1, 16'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 2'b00); tick();
    chk_all("tmo4_tie", 1'b0, 2'b01, 1'b0, 16'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00); tick();
    chk_all("tmo4_irq", 1'b1, 2'b01, 1'b0, 16'd1);
`else
    // No watchdog: a nonzero limit must not end the job.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00); tick();
    timeout_cycles = 32'd3;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b00); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    for (int i = 0; i < 6; i++) tick();
    chk_all("nowd_armed", 1'b0, 2'b00, 1'b1, 16'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 2'b11); tick();
    chk_all("nowd_done", 1'b0, 2'b01, 1'b0, 16'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
